// File: rtl/pc_if.sv
// pc_if: fetch-stage control/status bundle between decode/testbench and pc_unit.
//   master : drives en, PCsrc, ImmOp, rs1_val, halt_req, resume, trap_clear;
//            observes PC, PC_plus4, halted, trap, bad_addr, instr_count.
//   slave  : the pc_unit side (mirror directions).
// ADDR_WIDTH here must match the ADDR_WIDTH of the pc_unit it is bound to.
interface pc_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  en;
  logic [1:0]            PCsrc;
  logic [31:0]           ImmOp;
  logic [31:0]           rs1_val;
  logic                  halt_req;
  logic                  resume;
  logic                  trap_clear;
  logic [ADDR_WIDTH-1:0] PC;
  logic [ADDR_WIDTH-1:0] PC_plus4;
  logic                  halted;
  logic                  trap;
  logic [ADDR_WIDTH-1:0] bad_addr;
  logic [31:0]           instr_count;

  modport master (
    output en, PCsrc, ImmOp, rs1_val, halt_req, resume, trap_clear,
    input  PC, PC_plus4, halted, trap, bad_addr, instr_count
  );

  modport slave (
    input  en, PCsrc, ImmOp, rs1_val, halt_req, resume, trap_clear,
    output PC, PC_plus4, halted, trap, bad_addr, instr_count
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-side program counter with run/halt/trap control.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : pc_if.slave
//     en          advance enable (0 = stall, holds everything in RUN)
//     PCsrc       00 seq, 01 PC+ImmOp, 10 (rs1_val+ImmOp)&~1, 11 as seq
//     ImmOp       sign-extended immediate
//     rs1_val     JALR base register value
//     halt_req    EBREAK in current instruction -> HALT
//     resume      pulse: HALT -> RUN, stepping PC past the EBREAK
//     trap_clear  pulse: TRAP -> RUN, PC stays at TRAP_VECTOR
//     PC          current fetch address (ROM A)
//     PC_plus4    PC+4, combinational link value
//     halted/trap state decodes (registered)
//     bad_addr    last misaligned target that caused a trap
//     instr_count number of PC advances
module pc_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 'h0100
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic [31:0]           instr_count_q, instr_count_d;

  logic [ADDR_WIDTH-1:0] seq_t, br_t, jr_t, tgt;
  logic                  misaligned;
  logic                  halted_o, trap_o;

  // Target candidates. All sums are taken modulo 2^ADDR_WIDTH; the upper
  // immediate bits cannot influence the truncated branch result, so the
  // branch adder is kept at ADDR_WIDTH bits.
  assign seq_t = pc_q + ADDR_WIDTH'(4);
  assign br_t  = pc_q + bus.ImmOp[ADDR_WIDTH-1:0];
  assign jr_t  = ADDR_WIDTH'(bus.rs1_val + bus.ImmOp) & ~ADDR_WIDTH'(1);

  always_comb begin
    tgt = seq_t;
    unique case (bus.PCsrc)
      2'b01:   tgt = br_t;
      2'b10:   tgt = jr_t;
      default: tgt = seq_t;   // 00 and the reserved 11
    endcase
  end

  // Checked after bit0 clearing, so a JALR fault is only ever caused by bit1.
  assign misaligned = |tgt[1:0];

  // State register (and datapath flops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_VECTOR;
      bad_addr_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      bad_addr_q    <= bad_addr_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state logic. halt_req wins over the alignment check; en only
  // matters in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.en) begin
          if (bus.halt_req)  state_d = ST_HALT;
          else if (misaligned) state_d = ST_TRAP;
        end
      end
      ST_HALT: if (bus.resume)     state_d = ST_RUN;
      ST_TRAP: if (bus.trap_clear) state_d = ST_RUN;
      default:                     state_d = ST_RUN;
    endcase
  end

  // Datapath next values, keyed off the same decisions as the FSM.
  always_comb begin
    pc_d          = pc_q;
    bad_addr_d    = bad_addr_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.en && !bus.halt_req) begin
          if (misaligned) begin
            bad_addr_d = tgt;
            pc_d       = TRAP_VECTOR;
          end else begin
            pc_d          = tgt;
            instr_count_d = instr_count_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        // Resuming steps over the EBREAK and counts it as retired.
        if (bus.resume) begin
          pc_d          = seq_t;
          instr_count_d = instr_count_q + 32'd1;
        end
      end
      default: ;  // TRAP: everything holds; clearing only changes state
    endcase
  end

  // Output decode (state only, no combinational input paths).
  always_comb begin
    halted_o = (state_q == ST_HALT);
    trap_o   = (state_q == ST_TRAP);
  end

  assign bus.PC          = pc_q;
  assign bus.PC_plus4    = seq_t;
  assign bus.halted      = halted_o;
  assign bus.trap        = trap_o;
  assign bus.bad_addr    = bad_addr_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table, hand sequences for halt hold / stall /
// asynchronous reset, then randomized stimulus against a behavioural model.
module tb_pc_unit;
  localparam int          AW    = 16;
  localparam int unsigned MASK  = (1 << AW) - 1;
  localparam int unsigned TRAPV = 32'h0100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_if #(.ADDR_WIDTH(AW)) bus ();

  pc_unit #(.ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic hr, input logic rs, input logic tc);
    bus.en = en; bus.PCsrc = src; bus.ImmOp = imm; bus.rs1_val = rs1;
    bus.halt_req = hr; bus.resume = rs; bus.trap_clear = tc;
  endtask

  // One rising edge, then settle; inputs are changed only here (+1).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int unsigned pc, input bit h, input bit t,
                         input int unsigned bad, input int unsigned cnt);
    chk({tag, ".PC"},          64'(bus.PC),          64'(pc));
    chk({tag, ".PC_plus4"},    64'(bus.PC_plus4),    64'((pc + 4) & MASK));
    chk({tag, ".halted"},      64'(bus.halted),      64'(h));
    chk({tag, ".trap"},        64'(bus.trap),        64'(t));
    chk({tag, ".bad_addr"},    64'(bus.bad_addr),    64'(bad));
    chk({tag, ".instr_count"}, 64'(bus.instr_count), 64'(cnt));
  endtask

  // Called at +1 after an edge; reset asserts and releases between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        hr, rs, tc;
    int unsigned pc;
    bit          h, t;
    int unsigned bad;
    int unsigned cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic en, logic [1:0] src, logic [31:0] imm, logic [31:0] rs1,
                             logic hr, logic rs, logic tc, int unsigned pc, bit h, bit t,
                             int unsigned bad, int unsigned cnt);
    vec_t r;
    r.en = en; r.src = src; r.imm = imm; r.rs1 = rs1; r.hr = hr; r.rs = rs; r.tc = tc;
    r.pc = pc; r.h = h; r.t = t; r.bad = bad; r.cnt = cnt;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_RUN = 0, M_HALT = 1, M_TRAP = 2;
  int          m_st;
  int unsigned m_pc, m_bad, m_cnt;

  task automatic model_clk(input bit en, input int unsigned src, input int unsigned imm,
                           input int unsigned rs1, input bit hr, input bit rs, input bit tc);
    int unsigned t;
    case (m_st)
      M_RUN: if (en) begin
        if (hr) m_st = M_HALT;
        else begin
          if (src == 1)      t = m_pc + imm;
          else if (src == 2) t = (rs1 + imm) & ~32'd1;
          else               t = m_pc + 4;
          t = t & MASK;
          if (t % 4 != 0) begin m_bad = t; m_pc = TRAPV; m_st = M_TRAP; end
          else begin m_pc = t; m_cnt = m_cnt + 1; end
        end
      end
      M_HALT: if (rs) begin m_pc = (m_pc + 4) & MASK; m_cnt = m_cnt + 1; m_st = M_RUN; end
      default: if (tc) m_st = M_RUN;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("reset0", 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;

    //        en src imm            rs1    hr rs tc  pc       h t bad   cnt
    tv.push_back(v(1, 0, 32'h0,        32'h0,  0, 0, 0, 32'h4,    0, 0, 0,    1));
    tv.push_back(v(1, 0, 32'h0,        32'h0,  0, 0, 0, 32'h8,    0, 0, 0,    2));
    tv.push_back(v(1, 1, 32'hFFFFFFF8, 32'h0,  0, 0, 0, 32'h0,    0, 0, 0,    3));
    tv.push_back(v(1, 2, 32'h10,       32'h41, 0, 0, 0, 32'h50,   0, 0, 0,    4));
    tv.push_back(v(1, 2, 32'h0,        32'h12, 0, 0, 0, 32'h100,  0, 1, 32'h12, 4));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 0, 0, 32'h100,  0, 1, 32'h12, 4));
    tv.push_back(v(1, 1, 32'h4,        32'h0,  0, 0, 0, 32'h100,  0, 1, 32'h12, 4));
    tv.push_back(v(1, 0, 32'h0,        32'h0,  0, 1, 0, 32'h100,  0, 1, 32'h12, 4));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  0, 0, 32'h12, 4));
    tv.push_back(v(1, 0, 32'h0,        32'h0,  0, 0, 0, 32'h104,  0, 0, 32'h12, 5));
    tv.push_back(v(1, 1, 32'hFFFFFF1C, 32'h0,  0, 0, 0, 32'h20,   0, 0, 32'h12, 6));
    tv.push_back(v(1, 1, 32'h8,        32'h0,  1, 0, 0, 32'h20,   1, 0, 32'h12, 6));
    tv.push_back(v(1, 1, 32'h8,        32'h0,  1, 0, 1, 32'h20,   1, 0, 32'h12, 6));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 1, 1, 32'h24,   0, 0, 32'h12, 7));
    tv.push_back(v(1, 1, 32'hFFFFFFD8, 32'h0,  0, 0, 0, 32'hFFFC, 0, 0, 32'h12, 8));
    tv.push_back(v(1, 0, 32'h0,        32'h0,  0, 0, 1, 32'h0,    0, 0, 32'h12, 9));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 0, 0, 32'h0,    0, 0, 32'h12, 9));
    tv.push_back(v(1, 3, 32'h1234,     32'h0,  0, 0, 0, 32'h4,    0, 0, 32'h12, 10));
    tv.push_back(v(1, 1, 32'h2,        32'h0,  0, 0, 0, 32'h100,  0, 1, 32'h6,  10));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 0, 1, 32'h100,  0, 0, 32'h6,  10));
    tv.push_back(v(1, 1, 32'h1,        32'h0,  1, 0, 0, 32'h100,  1, 0, 32'h6,  10));
    tv.push_back(v(0, 0, 32'h0,        32'h0,  0, 1, 0, 32'h104,  0, 0, 32'h6,  11));

    foreach (tv[i]) begin
      drive(tv[i].en, tv[i].src, tv[i].imm, tv[i].rs1, tv[i].hr, tv[i].rs, tv[i].tc);
      step();
      chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].h, tv[i].t, tv[i].bad, tv[i].cnt);
    end

    // ---- halt held 10 cycles with en=1, PCsrc=01, then resume ----
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 1, 32'h20, 0, 0, 0, 0); step();
    chk_all("to20", 32'h20, 0, 0, 0, 1);
    drive(1, 1, 32'h8, 0, 1, 0, 0); step();
    chk_all("halt", 32'h20, 1, 0, 0, 1);
    drive(1, 1, 32'h8, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), 32'h20, 1, 0, 0, 1);
    end
    drive(1, 1, 32'h8, 0, 0, 1, 0); step();
    chk_all("resume", 32'h24, 0, 0, 0, 2);

    // ---- stall: en=0 freezes PC and count ----
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 32'h24, 0, 0, 0, 2);
    end

    // ---- asynchronous reset while HALT ----
    drive(1, 0, 0, 0, 1, 0, 0); step();
    chk_all("halt2", 32'h24, 1, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // ---- asynchronous reset while TRAP ----
    step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk_all("seq", 32'h4, 0, 0, 0, 1);
    drive(1, 2, 32'h0, 32'h12, 0, 0, 0); step();
    chk_all("trap2", 32'h100, 0, 1, 32'h12, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // ---- randomized run against the model ----
    m_st = M_RUN; m_pc = 0; m_bad = 0; m_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      bit          en, hr, rs, tc;
      int unsigned src, imm, rs1;
      en  = ($urandom_range(0, 3) != 0);
      src = $urandom_range(0, 3);
      imm = 32'($urandom_range(0, 64)) - 32'd32;
      if ($urandom_range(0, 3) != 0) imm = imm & ~32'd3;
      if ($urandom_range(0, 15) == 0) imm = $urandom() & ~32'd3;
      rs1 = $urandom_range(0, 255);
      hr  = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      tc  = ($urandom_range(0, 3) == 0);
      drive(en, src[1:0], imm, rs1, hr, rs, tc);
      model_clk(en, src, imm, rs1, hr, rs, tc);
      step();
      chk_all($sformatf("rnd%0d", k), m_pc, m_st == M_HALT, m_st == M_TRAP, m_bad, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
